calc_op_sequencer: RTL and testbench

//   Command sequencer directly upstream of the 16-way one-hot result Multiplexer.

---
 rtl/calc_op_sequencer_pkg.sv | 27 ++
 rtl/calc_op_sequencer_if.sv | 32 +++
 rtl/calc_timeout_counter.sv | 28 ++
 rtl/calc_op_sequencer.sv | 117 +++++++++++
 tb/tb_calc_op_sequencer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/calc_op_sequencer_pkg.sv
// Shared calculator definitions: widths, opcode names, sequencer state encoding
// and the default multicycle mask used by the sequencer and the unit wrapper.
package calc_op_sequencer_pkg;

  localparam int CALC_DATA_W   = 32;
  localparam int CALC_OPCODE_W = 4;
  localparam int CALC_NUM_OPS  = 16;

  localparam logic [CALC_NUM_OPS-1:0] DEFAULT_MULTICYCLE_MASK = 16'h0000;

  typedef enum logic [CALC_OPCODE_W-1:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_DIV, OP_MOD,
    OP_SHL, OP_SHR, OP_SRA, OP_ROL, OP_ROR, OP_MIN, OP_MAX, OP_SQRT
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESULT
  } state_t;

  function automatic logic [CALC_NUM_OPS-1:0] op_onehot(input logic [CALC_OPCODE_W-1:0] op);
    op_onehot     = '0;
    op_onehot[op] = 1'b1;
  endfunction

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Host command and downstream result handshakes of the calculator sequencer.
interface calc_op_sequencer_if
  import calc_op_sequencer_pkg::*;
#(
  parameter int DATA_W = CALC_DATA_W
) ();

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [CALC_OPCODE_W-1:0] cmd_opcode;
  logic [DATA_W-1:0]        cmd_a;
  logic [DATA_W-1:0]        cmd_b;

  logic                     res_valid;
  logic                     res_ready;
  logic [DATA_W-1:0]        res_data;
  logic [CALC_OPCODE_W-1:0] res_opcode;
  logic                     res_err;

  // master: host issuing commands and consuming results
  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_opcode, res_err
  );

  // slave: the sequencer
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_opcode, res_err
  );

endinterface

// File: rtl/calc_timeout_counter.sv
// EXEC-cycle counter for multicycle ops; expired flags the TIMEOUT-th cycle.
module calc_timeout_counter #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // saturates at LAST so a stalled enable can never wrap back to zero
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/calc_op_sequencer.sv
// Command sequencer ahead of the one-hot result mux: issues one op at a time,
// waits for completion (or timeout) and returns the captured result.
module calc_op_sequencer
  import calc_op_sequencer_pkg::*;
#(
  parameter int                      DATA_W          = CALC_DATA_W,
  parameter logic [CALC_NUM_OPS-1:0] MULTICYCLE_MASK = DEFAULT_MULTICYCLE_MASK,
  parameter int                      TIMEOUT         = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  calc_op_sequencer_if.slave      bus,
  output logic [DATA_W-1:0]       op_a,
  output logic [DATA_W-1:0]       op_b,
  output logic                    op_start,
  output logic [CALC_NUM_OPS-1:0] hotselect,
  input  logic                    unit_done,
  input  logic [DATA_W-1:0]       muxout
);

  state_t                   state, state_next;
  logic [CALC_OPCODE_W-1:0] cur_op;
  logic                     cmd_ready_q;
  logic                     res_valid_q;
  logic [DATA_W-1:0]        res_data_q;
  logic [CALC_OPCODE_W-1:0] res_opcode_q;
  logic                     res_err_q;

  logic accept, finish_ok, finish_to, handshake, expired;

  calc_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  (state == ST_EXEC),
    .expired (expired)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish_ok  = 1'b0;
    finish_to  = 1'b0;
    handshake  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          accept     = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // done has priority over a coincident timeout
        if (!MULTICYCLE_MASK[cur_op] || unit_done) begin
          finish_ok  = 1'b1;
          state_next = ST_RESULT;
        end else if (expired) begin
          finish_to  = 1'b1;
          state_next = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (bus.res_ready) begin
          handshake  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cur_op       <= '0;
      cmd_ready_q  <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      op_start     <= 1'b0;
      hotselect    <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_opcode_q <= '0;
      res_err_q    <= 1'b0;
    end else begin
      state       <= state_next;
      // ready is registered from the next state, so it rises the cycle after a handshake
      cmd_ready_q <= (state_next == ST_IDLE);
      op_start    <= accept;
      if (accept) begin
        cur_op    <= bus.cmd_opcode;
        op_a      <= bus.cmd_a;
        op_b      <= bus.cmd_b;
        hotselect <= op_onehot(bus.cmd_opcode);
      end
      if (finish_ok || finish_to) begin
        hotselect    <= '0;
        res_valid_q  <= 1'b1;
        res_data_q   <= finish_ok ? muxout : '0;
        res_opcode_q <= cur_op;
        res_err_q    <= finish_to;
      end
      if (handshake) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_opcode = res_opcode_q;
  assign bus.res_err    = res_err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer: a TIMEOUT=8 instance plus a TIMEOUT=256
// instance on shared stimulus for the long multicycle case.
module tb_calc_op_sequencer;
  import calc_op_sequencer_pkg::*;

  localparam int          DW   = 32;
  localparam logic [15:0] MASK = 16'h8028;  // ops 3, 5, 15 are multicycle

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic          cmd_valid  = 1'b0;
  logic [3:0]    cmd_opcode = '0;
  logic [DW-1:0] cmd_a      = '0;
  logic [DW-1:0] cmd_b      = '0;
  logic          res_ready  = 1'b0;
  logic          unit_done  = 1'b0;
  logic [DW-1:0] muxout     = '0;

  logic [DW-1:0] op_a_a, op_b_a, op_a_b, op_b_b;
  logic          op_start_a, op_start_b;
  logic [15:0]   hot_a, hot_b;

  int unsigned checks = 0;
  int unsigned passed = 0;

  calc_op_sequencer_if #(.DATA_W(DW)) bus_a ();
  calc_op_sequencer_if #(.DATA_W(DW)) bus_b ();

  assign bus_a.cmd_valid  = cmd_valid;
  assign bus_a.cmd_opcode = cmd_opcode;
  assign bus_a.cmd_a      = cmd_a;
  assign bus_a.cmd_b      = cmd_b;
  assign bus_a.res_ready  = res_ready;
  assign bus_b.cmd_valid  = cmd_valid;
  assign bus_b.cmd_opcode = cmd_opcode;
  assign bus_b.cmd_a      = cmd_a;
  assign bus_b.cmd_b      = cmd_b;
  assign bus_b.res_ready  = res_ready;

  calc_op_sequencer #(
    .DATA_W(DW), .MULTICYCLE_MASK(MASK), .TIMEOUT(8)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a),
    .op_a(op_a_a), .op_b(op_b_a), .op_start(op_start_a), .hotselect(hot_a),
    .unit_done(unit_done), .muxout(muxout)
  );

  calc_op_sequencer #(
    .DATA_W(DW), .MULTICYCLE_MASK(MASK), .TIMEOUT(256)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .op_a(op_a_b), .op_b(op_b_b), .op_start(op_start_b), .hotselect(hot_b),
    .unit_done(unit_done), .muxout(muxout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus_a.cmd_ready && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", 32'(bus_a.cmd_ready), 1);
  endtask

  // presents one command for the accepting edge; returns in the first EXEC cycle
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    wait_ready();
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    tick();
    cmd_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_cmd_ready", 32'(bus_a.cmd_ready), 0);
    chk("rst_res_valid", 32'(bus_a.res_valid), 0);
    chk("rst_hotselect", 32'(hot_a), 0);
    chk("rst_op_start",  32'(op_start_a), 0);
    chk("rst_res_err",   32'(bus_a.res_err), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 32'(bus_a.cmd_ready), 1);

    // single-cycle op 0
    muxout    = 32'd7;
    res_ready = 1'b1;
    issue(4'd0, 32'd3, 32'd4);
    chk("s0_hotselect", 32'(hot_a), 'h0001);
    chk("s0_op_start",  32'(op_start_a), 1);
    chk("s0_op_a",      op_a_a, 3);
    chk("s0_op_b",      op_b_a, 4);
    chk("s0_cmd_ready", 32'(bus_a.cmd_ready), 0);
    chk("s0_res_valid_early", 32'(bus_a.res_valid), 0);
    tick();
    chk("s0_res_valid",  32'(bus_a.res_valid), 1);
    chk("s0_res_data",   bus_a.res_data, 7);
    chk("s0_res_opcode", 32'(bus_a.res_opcode), 0);
    chk("s0_res_err",    32'(bus_a.res_err), 0);
    chk("s0_hot_clear",  32'(hot_a), 0);
    chk("s0_start_pulse", 32'(op_start_a), 0);
    tick();
    chk("s0_res_dropped", 32'(bus_a.res_valid), 0);

    // reset while multicycle op 5 is pending
    muxout = '0;
    issue(4'd5, 32'd1, 32'd1);
    tick();
    chk("r5_hotselect", 32'(hot_a), 'h0020);
    reset = 1'b1;
    tick();
    chk("r5_res_valid", 32'(bus_a.res_valid), 0);
    chk("r5_hotselect_clr", 32'(hot_a), 0);
    chk("r5_cmd_ready", 32'(bus_a.cmd_ready), 0);
    chk("r5_op_a", op_a_a, 0);
    reset = 1'b0;
    tick();
    chk("r5_cmd_ready_back", 32'(bus_a.cmd_ready), 1);
    unit_done = 1'b1;
    muxout    = 32'd1;
    for (int i = 0; i < 3; i++) begin
      chk("r5_no_stale", 32'(bus_a.res_valid), 0);
      tick();
    end
    unit_done = 1'b0;

    // multicycle op 15 on the long-timeout instance, done in the 10th EXEC cycle
    muxout = 32'hDEADBEEF;
    issue(4'd15, 32'd10, 32'd20);
    for (int k = 1; k <= 10; k++) begin
      chk("m15_hotselect", 32'(hot_b), 'h8000);
      chk("m15_res_valid_exec", 32'(bus_b.res_valid), 0);
      if (k == 10) unit_done = 1'b1;
      tick();
    end
    unit_done = 1'b0;
    chk("m15_res_valid",  32'(bus_b.res_valid), 1);
    chk("m15_res_data",   bus_b.res_data, 32'hDEADBEEF);
    chk("m15_res_err",    32'(bus_b.res_err), 0);
    chk("m15_res_opcode", 32'(bus_b.res_opcode), 15);
    chk("m15_hot_clear",  32'(hot_b), 0);
    chk("m15_a_done_ignored", 32'(bus_a.res_valid), 0);
    tick();

    // multicycle op 3 timing out after 8 EXEC cycles
    muxout = 32'h12345678;
    issue(4'd3, 32'd5, 32'd6);
    for (int k = 1; k <= 8; k++) begin
      chk("t3_hotselect", 32'(hot_a), 'h0008);
      chk("t3_res_valid_exec", 32'(bus_a.res_valid), 0);
      tick();
    end
    chk("t3_res_valid",  32'(bus_a.res_valid), 1);
    chk("t3_res_data",   bus_a.res_data, 0);
    chk("t3_res_err",    32'(bus_a.res_err), 1);
    chk("t3_res_opcode", 32'(bus_a.res_opcode), 3);
    chk("t3_hot_clear",  32'(hot_a), 0);
    tick();

    // done in exactly the timeout cycle: done wins
    muxout = 32'hCAFEF00D;
    issue(4'd3, 32'd7, 32'd8);
    for (int k = 1; k <= 8; k++) begin
      chk("d3_res_valid_exec", 32'(bus_a.res_valid), 0);
      if (k == 8) unit_done = 1'b1;
      tick();
    end
    unit_done = 1'b0;
    chk("d3_res_valid", 32'(bus_a.res_valid), 1);
    chk("d3_res_err",   32'(bus_a.res_err), 0);
    chk("d3_res_data",  bus_a.res_data, 32'hCAFEF00D);
    tick();

    // backpressure on single-cycle op 9 with a new command waiting
    res_ready = 1'b0;
    muxout    = 32'h55;
    issue(4'd9, 32'd1, 32'd2);
    tick();
    cmd_valid  = 1'b1;
    cmd_opcode = 4'd1;
    cmd_a      = 32'd11;
    cmd_b      = 32'd12;
    muxout     = 32'h99;
    for (int i = 0; i < 5; i++) begin
      chk("bp_res_valid",  32'(bus_a.res_valid), 1);
      chk("bp_res_data",   bus_a.res_data, 32'h55);
      chk("bp_res_opcode", 32'(bus_a.res_opcode), 9);
      chk("bp_cmd_ready",  32'(bus_a.cmd_ready), 0);
      tick();
    end
    res_ready = 1'b1;
    chk("bp_cmd_ready_hs", 32'(bus_a.cmd_ready), 0);
    tick();
    chk("bp_res_released", 32'(bus_a.res_valid), 0);
    chk("bp_cmd_ready_up", 32'(bus_a.cmd_ready), 1);
    chk("bp_not_taken",    32'(hot_a), 0);
    tick();
    cmd_valid = 1'b0;
    chk("bp_next_hot",   32'(hot_a), 'h0002);
    chk("bp_next_start", 32'(op_start_a), 1);
    chk("bp_next_op_a",  op_a_a, 11);
    tick();
    chk("bp_next_res_valid",  32'(bus_a.res_valid), 1);
    chk("bp_next_res_data",   bus_a.res_data, 32'h99);
    chk("bp_next_res_opcode", 32'(bus_a.res_opcode), 1);
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
